// File: rtl/dmem_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_port: load/store port between core controller and word memory bus.  |
// | Optional misalignment trap: define DMEM_MISALIGN_TRAP_EN.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dmem_port #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RREQ,
  input  logic        CWE,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  input  logic [2:0]  LIM,
  input  logic        SIGNED,
  output logic [31:0] RDATA,
  output logic        RDY,
  output logic        ERR,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [29:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_BE,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK
);
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    size_q;
  logic [1:0]    off_q;
  logic          sgn_q;
  logic          we_q;

  logic [1:0]    size_d;
  logic [1:0]    off_d;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [31:0]   rdata_d;
  logic [7:0]    byte_w;
  logic [15:0]   half_w;
  logic [CW-1:0] cnt_inc_w;
  logic          trap_w;

  // size code: 0 = byte, 1 = half, 2 = word
  assign size_d    = (LIM == 3'd0) ? 2'd0 : (LIM == 3'd1) ? 2'd1 : 2'd2;
  assign cnt_inc_w = cnt_q + CW'(1);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap_w = ((size_d == 2'd1) && ADDR[0]) ||
                  ((size_d == 2'd2) && (ADDR[1:0] != 2'b00));
`else
  assign trap_w = 1'b0;
`endif

  always_comb begin
    off_d   = 2'b00;
    be_d    = 4'hF;
    wdata_d = WDATA;
    case (size_d)
      2'd0: begin
        off_d   = ADDR[1:0];
        be_d    = 4'b0001 << off_d;
        wdata_d = {4{WDATA[7:0]}};
      end
      2'd1: begin
        off_d   = {ADDR[1], 1'b0};
        be_d    = 4'b0011 << off_d;
        wdata_d = {2{WDATA[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_w = MEM_RDATA[7:0];
    case (off_q)
      2'd1:    byte_w = MEM_RDATA[15:8];
      2'd2:    byte_w = MEM_RDATA[23:16];
      2'd3:    byte_w = MEM_RDATA[31:24];
      default: ;
    endcase
    half_w  = off_q[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
    rdata_d = MEM_RDATA;
    case (size_q)
      2'd0:    rdata_d = {{24{sgn_q & byte_w[7]}}, byte_w};
      2'd1:    rdata_d = {{16{sgn_q & half_w[15]}}, half_w};
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      size_q    <= 2'd0;
      off_q     <= 2'd0;
      sgn_q     <= 1'b0;
      we_q      <= 1'b0;
      RDATA     <= 32'd0;
      RDY       <= 1'b0;
      ERR       <= 1'b0;
      MEM_REQ   <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= 30'd0;
      MEM_WDATA <= 32'd0;
      MEM_BE    <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (CWE || RREQ) begin
            size_q <= size_d;
            off_q  <= off_d;
            sgn_q  <= SIGNED;
            we_q   <= CWE;
            if (trap_w) begin
              state_q <= DONE;
            end else begin
              MEM_REQ   <= 1'b1;
              MEM_WE    <= CWE;
              MEM_ADDR  <= ADDR[31:2];
              MEM_WDATA <= wdata_d;
              MEM_BE    <= be_d;
              cnt_q     <= '0;
              state_q   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
            RDY     <= 1'b1;
            ERR     <= 1'b0;
            if (!we_q) begin
              RDATA <= rdata_d;
            end
            state_q <= DONE;
          end else if ((TIMEOUT != 0) && (cnt_inc_w == C_TIMEOUT)) begin
            MEM_REQ <= 1'b0;
            RDY     <= 1'b1;
            ERR     <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_inc_w;
          end
        end
        DONE: begin
          // A trapped access arrives here with RDY low and pulses it one cycle later
          if (RDY) begin
            RDY     <= 1'b0;
            ERR     <= 1'b0;
            state_q <= IDLE;
          end else begin
            RDY <= 1'b1;
            ERR <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: doc/dmem_port.md
# dmem_port

Load/store memory port sitting directly downstream of the core controller. Accepts the controller's one-cycle `RREQ`/`CWE` strobes with `LIM`/`SIGNED` and the ALU-computed byte address. It drives a word-wide request/acknowledge memory bus with byte enables, and returns lane-aligned, sign/zero-extended load data together with the single-cycle `RDY` completion pulse the controller waits on. It also owns access-timeout detection and, optionally, misalignment trapping.

## Interface
- `TIMEOUT`, 255: cycles `MEM_REQ` may stay high without `MEM_ACK` before the access aborts; 0 disables the timeout.
- `CLK` in 1: clock; all state updates on posedge.
- `RST` in 1: synchronous, active-high reset.
- `RREQ` in 1: load strobe, high for one cycle.
- `CWE` in 1: store strobe, high for one cycle.
- `ADDR` in 32: byte address.
- `WDATA` in 32: store data, right-justified.
- `LIM` in 3: access size; 0 = byte, 1 = half, any other value = word.
- `SIGNED` in 1: sign-extend load data when 1, zero-extend when 0.
- `RDATA` out 32: aligned, extended load result.
- `RDY` out 1: one-cycle completion pulse.
- `ERR` out 1: qualifies `RDY`; high means the access was aborted.
- `MEM_REQ` out 1: bus request, held until acknowledged.
- `MEM_WE` out 1: bus write.
- `MEM_ADDR` out 30: word address, equal to `ADDR[31:2]`.
- `MEM_WDATA` out 32: lane-replicated store data.
- `MEM_BE` out 4: byte enables.
- `MEM_RDATA` in 32: bus read data, valid with `MEM_ACK`.
- `MEM_ACK` in 1: bus acknowledge.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: on `CWE`, or `RREQ`, latch `ADDR`, `WDATA`, `LIM`, `SIGNED` and the op type, then go to BUSY.
  - If both strobes are high, `CWE` wins; the read is dropped.
  - `RREQ`/`CWE` are ignored outside IDLE.
- BUSY: `MEM_REQ`=1 and `MEM_WE`/`MEM_ADDR`/`MEM_WDATA`/`MEM_BE` are held stable.
  - On `MEM_ACK`=1: capture `MEM_RDATA` for loads, drop `MEM_REQ`, go to DONE.
- DONE: `RDY`=1 for exactly one cycle, then go to IDLE.
- Byte offset is `a = ADDR[1:0]`.
- Byte enables:
  - byte: `MEM_BE = 4'b0001 << a`.
  - half: `MEM_BE = 4'b0011 << {a[1],1'b0}`.
  - word: `MEM_BE = 4'b1111`.
- Store data: byte → `{4{WDATA[7:0]}}`; half → `{2{WDATA[15:0]}}`; word → `WDATA`.
- Load data: select lane(s) by `a` as above, then sign- or zero-extend to 32 bits per `SIGNED`. `RDATA` updates only on successful load completion and holds otherwise; stores leave it unchanged.
- Timeout:
  - An 8+-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches `TIMEOUT`: drop `MEM_REQ`, go to DONE with `ERR`=1.
  - Ack in the same cycle as expiry counts as success.
- `ERR` is 0 on every normal completion.

## Timing
- Reset values: `RDATA`=0, `RDY`=0, `ERR`=0, `MEM_REQ`=0, `MEM_WE`=0, `MEM_ADDR`=0, `MEM_WDATA`=0, `MEM_BE`=0, FSM=IDLE, counter=0.
- Strobe sampled at edge N → `MEM_REQ` high from N+1.
- Ack sampled at edge N+1+k → `RDY` high for cycle N+2+k, with `RDATA` valid in that same cycle.
- Zero-wait memory (ack on first request cycle): `RDY` two cycles after the strobe.
- `RDY` is a full-cycle registered pulse, so the controller's negedge sampling sees it exactly once.
- Next strobe is accepted in the cycle after `RDY`.
- Reset mid-access: `MEM_REQ` drops at the reset edge, no `RDY` is produced, and a late `MEM_ACK` is ignored.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A half access with `a[0]`=1, or a word access with `a`≠0, never raises `MEM_REQ`.
  - FSM goes IDLE→DONE; `RDY`=1 and `ERR`=1 two cycles after the strobe.
- Undefined:
  - Low address bits are forced to alignment: half uses `a[1]` only, word ignores `a`.
  - The access proceeds normally and `ERR` is never set by alignment.

## Test plan
- Store byte: `ADDR`=0x103, `WDATA`=0x000000A5, `LIM`=0 → `MEM_ADDR`=0x40, `MEM_BE`=4'b1000, `MEM_WDATA`=0xA5A5A5A5, `MEM_WE`=1; `RDY` 2 cycles after the strobe with zero-wait ack.
- Load half, signed then unsigned: `ADDR`=0x202, `MEM_RDATA`=0x8001_1234 → `RDATA`=0xFFFF8001 with `SIGNED`=1, and 0x00008001 with `SIGNED`=0.
- Wait states: ack delayed 5 cycles → `MEM_REQ` and all bus outputs stable for 6 cycles; `RDY` one cycle after ack, `ERR`=0.
- Timeout with `TIMEOUT`=4 and no ack → `MEM_REQ` high 4 cycles, then `RDY`=1 with `ERR`=1; `RDATA` unchanged.
- Load word at `ADDR`=0x6:
  - With `DMEM_MISALIGN_TRAP_EN`: no `MEM_REQ`; `RDY`/`ERR`=1 after 2 cycles.
  - Without it: `MEM_ADDR`=0x1, `MEM_BE`=4'hF.
- `RST` asserted while BUSY, ack arriving next cycle → `MEM_REQ`=0 and no `RDY`; a new `RREQ` after reset completes normally.
